spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
SPI target (slave) that pairs with spi_master. It receives 16-bit MOSI frames and returns 16-bit MISO frames while nss is low. sck, nss and mosi are asynchronous inputs; the block oversamples them in the clk domain. It presents valid/ready byte-lane-free word interfaces and an 8-bit status flag register to local logic.

Parameters:
DATA_W, 16, frame length in bits; the shift order is MSB first.
TX_IDLE, 16'h0000, word shifted out when no TX word is pending (underrun).
SYNC_STAGES, 2, flip-flop synchronizer depth on sck, nss and mosi; minimum 2.

Ports:
clk  input  1  system clock; must be at least 8x the sck frequency.
rst  input  1  asynchronous, active-high reset.
sck  input  1  SPI clock from the master; CPOL=0.
nss  input  1  active-low frame select.
mosi  input  1  serial data from the master.
miso  output  1  serial data to the master; driven 0 while the frame is inactive.
tx_data  input  DATA_W  word to transmit.
tx_valid  input  1  tx_data is valid.
tx_ready  output  1  TX holding register is empty.
rx_data  output  DATA_W  last received word.
rx_valid  output  1  rx_data is valid; held until it is accepted.
rx_ready  input  1  consumer accepts rx_data.
flag  output  8  status bits: [0] busy, [1] rx_overrun, [2] tx_underrun, [3] frame_abort; [7:4] read as 0.
flag_clr  input  8  write-1-to-clear for flag[3:1], one cycle.

Behaviour:
- Reset values: miso=0, tx_ready=1, rx_valid=0, rx_data=0, flag=0, FSM=WAIT_HIGH, bit counter=0.
- Input conditioning:
  - SYNC_STAGES synchronizers feed a 1-cycle edge detector.
  - Total latency from a pin edge to the internal event is SYNC_STAGES+1 clk.
- Timing requirements on the master:
  - sck high and low phases each at least 4 clk.
  - nss fall to the first sck rise at least 4 clk.
- FSM states:
  - WAIT_HIGH: wait for synchronized nss=1, then go to IDLE. This discards any frame that was in progress at reset release.
  - IDLE: on an nss falling edge, run LOAD and go to SHIFT. Set busy.
  - SHIFT (mode 0):
    - sck rising edge: sample mosi into rx_shift LSB and increment the counter.
    - sck falling edge: shift tx_shift left and drive the new MSB onto miso.
    - When the counter reaches DATA_W on a rising edge, run COMPLETE. The counter resets to 0, the FSM stays in SHIFT, and back-to-back frames are supported without releasing nss.
    - On an nss rising edge: go to IDLE and clear busy. If the counter is neither 0 nor DATA_W, set frame_abort and discard the partial word.
- LOAD:
  - If the holding register is full, move it into tx_shift and set tx_ready=1.
  - Otherwise load TX_IDLE and set tx_underrun.
  - Drive miso = tx_shift MSB in the same cycle.
  - In back-to-back frames, LOAD happens at the first falling edge after COMPLETE.
- COMPLETE:
  - If rx_valid=0, or rx_valid and rx_ready are both 1 in this cycle, copy rx_shift to rx_data and set rx_valid=1.
  - Otherwise keep the old rx_data, drop the new word and set rx_overrun.
- Handshakes:
  - TX accept: tx_valid & tx_ready loads the holding register; tx_ready drops the next cycle.
  - Simultaneous accept and LOAD in the same cycle: LOAD uses the previous holding content. If the holding register was empty, the underrun still occurs and the new word stays held.
  - rx_valid falls the cycle after rx_valid & rx_ready.
- Flags:
  - Sticky until cleared by flag_clr.
  - If a set and a clear coincide, the set wins.
- rst asserted mid-frame: everything returns to reset values immediately and the FSM goes to WAIT_HIGH.

Optional Feature:
Macro SPI_SLAVE_CPHA1_EN.
- Defined: mode 1 (CPOL=0, CPHA=1). miso is updated on the sck rising edge and mosi is sampled on the falling edge. The first MSB is driven at the first rising edge, not at nss fall, and COMPLETE happens on the DATA_W-th falling edge.
- Undefined: mode 0 as described in Behaviour.

Decomposition:
- Package spi_pkg holds:
  - the state enum (WAIT_HIGH, IDLE, SHIFT);
  - the flag bit index localparams FLAG_BUSY=0, FLAG_OVR=1, FLAG_UDR=2, FLAG_ABT=3;
  - the default DATA_W of 16, shared with spi_master.
- Sub-module spi_sync_edge: a synchronizer plus rise/fall pulse detector, instantiated three times (sck, nss, mosi; for mosi only the level output is used).

Test Plan:
- Basic frame:
  - Stimulus: tx_data=16'hA5C3 preloaded; the master sends 16'h000A in mode 0 with sck period 16 clk.
  - Required: rx_data=16'h000A; rx_valid rises within SYNC_STAGES+2 clk of the 16th rise; the miso bit sequence equals 0xA5C3 MSB first; flag=0.
- Underrun:
  - Stimulus: no tx_valid before a frame.
  - Required: miso sends 16'h0000; flag[2]=1; after flag_clr=8'h04, flag[2]=0.
- Overrun:
  - Stimulus: two frames, 16'h1234 then 16'h5678, with rx_ready held at 0.
  - Required: rx_data stays 16'h1234; flag[1]=1.
- Back-to-back:
  - Stimulus: nss held low for 32 sck cycles, TX words 16'h1111 and 16'h2222 supplied.
  - Required: two rx_valid events; miso carries both words in order; flag[3]=0.
- Abort and reset:
  - Stimulus: nss rises after 7 bits.
  - Required: flag[3]=1 and no rx_valid.
  - Stimulus: rst pulsed mid-frame while nss is low.
  - Required: the frame is ignored until nss goes high and then low again, and the next full frame is received correctly.
- CPHA1 build:
  - Stimulus: the basic-frame test repeated in mode 1 with SPI_SLAVE_CPHA1_EN defined.
  - Required: identical rx_data and miso word.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, flag bit positions
// and the default frame width used by spi_master and spi_slave.
package spi_pkg;

    localparam int SPI_DATA_W = 16;

    localparam int FLAG_BUSY = 0;
    localparam int FLAG_OVR  = 1;
    localparam int FLAG_UDR  = 2;
    localparam int FLAG_ABT  = 3;

    typedef enum logic [1:0] {
        WAIT_HIGH,
        IDLE,
        SHIFT
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus a
// registered rise/fall pulse detector aligned with lvl.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;

    // Synchronize the pin, then register level and edge pulses together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            lvl  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            lvl  <= sync[STAGES-1];
            rise <= sync[STAGES-1] & ~lvl;
            fall <= ~sync[STAGES-1] & lvl;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI target, CPOL=0, MSB first, valid/ready word ports and flags.
// SPI_SLAVE_CPHA1_EN selects mode 1 (CPHA=1); default is mode 0.
module spi_slave
    import spi_pkg::*;
#(
    parameter int               DATA_W      = SPI_DATA_W,
    parameter logic [DATA_W-1:0] TX_IDLE    = '0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              nss,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [7:0]        flag,
    input  logic [7:0]        flag_clr
);

    localparam int CW = $clog2(DATA_W + 1);
`ifdef SPI_SLAVE_CPHA1_EN
    localparam bit CPHA1 = 1'b1;
`else
    localparam bit CPHA1 = 1'b0;
`endif

    spi_state_t        state, state_n;
    logic              sck_lvl, sck_rise, sck_fall;
    logic              nss_lvl, nss_rise, nss_fall;
    logic              mosi_lvl, mosi_rise, mosi_fall;
    logic              start, stop, abort, smp, drv;
    logic              smp_e, drv_e, cmpl;
    logic              ld_now, commit, preview, shift;
    logic              load, src, pop, udr, ovr;
    logic              first, pend, pend_src;
    logic              hold_full;
    logic [DATA_W-1:0] hold, word, tx_shift, rx_shift, rx_word;
    logic [CW-1:0]     cnt;
    logic [3:0]        flags, fset;
    logic              unused_ok;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
        .clk(clk), .rst(rst), .d(sck),
        .lvl(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_nss (
        .clk(clk), .rst(rst), .d(nss),
        .lvl(nss_lvl), .rise(nss_rise), .fall(nss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
        .clk(clk), .rst(rst), .d(mosi),
        .lvl(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_ok = ^{sck_lvl, mosi_rise, mosi_fall, pend,
                         flag_clr[7:4], flag_clr[0]};

`ifdef SPI_SLAVE_CPHA1_EN
    assign smp_e   = sck_fall;
    assign drv_e   = sck_rise;
    assign ld_now  = drv & first;
    assign commit  = 1'b0;
    assign preview = 1'b0;
`else
    assign smp_e   = sck_rise;
    assign drv_e   = sck_fall;
    assign ld_now  = start;
    assign commit  = smp & pend;
    assign preview = drv & first;
`endif

    // A mode-0 frame boundary only previews the next MSB on the falling
    // edge; the TX word is consumed at the following rise, so a trailing
    // sck fall before nss release never pops a word or flags underrun.
    assign shift   = drv & ~first;
    assign cmpl    = smp && (cnt == CW'(DATA_W - 1));
    assign rx_word = {rx_shift[DATA_W-2:0], mosi_lvl};
    assign load    = ld_now | commit;
    assign src     = ld_now ? hold_full : pend_src;
    assign word    = src ? hold : TX_IDLE;
    assign pop     = load & src;
    assign udr     = load & ~src;
    assign ovr     = cmpl & rx_valid & ~rx_ready;

    assign tx_ready = ~hold_full;
    assign flag     = {4'b0000, flags};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_HIGH;
        else     state <= state_n;
    end

    // Next state and per-cycle frame strobes.
    always_comb begin
        state_n = state;
        start   = 1'b0;
        stop    = 1'b0;
        abort   = 1'b0;
        smp     = 1'b0;
        drv     = 1'b0;
        unique case (state)
            WAIT_HIGH: if (nss_lvl) state_n = IDLE;
            IDLE: begin
                if (nss_fall) begin
                    state_n = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                if (nss_rise) begin
                    state_n = IDLE;
                    stop    = 1'b1;
                    abort   = (cnt != '0);
                end else begin
                    smp = smp_e;
                    drv = drv_e;
                end
            end
            default: state_n = WAIT_HIGH;
        endcase
    end

    // Shift registers, bit counter and miso driver.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift <= '0;
            rx_shift <= '0;
            cnt      <= '0;
            miso     <= 1'b0;
            first    <= 1'b0;
            pend     <= 1'b0;
            pend_src <= 1'b0;
        end else begin
            if (start | stop) begin
                cnt   <= '0;
                first <= start && CPHA1;
                pend  <= 1'b0;
            end
            if (stop) miso <= 1'b0;
            if (smp) begin
                rx_shift <= rx_word;
                cnt      <= cmpl ? '0 : cnt + CW'(1);
                if (cmpl) first <= 1'b1;
            end
            if (commit) pend <= 1'b0;
            if (load) begin
                tx_shift <= word;
                miso     <= word[DATA_W-1];
                if (ld_now && CPHA1) first <= 1'b0;
            end
            if (preview) begin
                miso     <= hold_full ? hold[DATA_W-1] : TX_IDLE[DATA_W-1];
                pend     <= 1'b1;
                pend_src <= hold_full;
                first    <= 1'b0;
            end
            if (shift) begin
                tx_shift <= tx_shift << 1;
                miso     <= tx_shift[DATA_W-2];
            end
        end
    end

    // TX holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (tx_valid && !hold_full) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
        end else if (pop) begin
            hold_full <= 1'b0;
        end
    end

    // RX output word and its valid/ready handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (cmpl && (!rx_valid || rx_ready)) begin
            rx_data  <= rx_word;
            rx_valid <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    always_comb begin
        fset           = '0;
        fset[FLAG_OVR] = ovr;
        fset[FLAG_UDR] = udr;
        fset[FLAG_ABT] = abort;
    end

    // Busy follows the frame; error flags are sticky, set beats clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= '0;
        end else begin
            if (start)     flags[FLAG_BUSY] <= 1'b1;
            else if (stop) flags[FLAG_BUSY] <= 1'b0;
            flags[3:1] <= (flags[3:1] & ~flag_clr[3:1]) | fset[3:1];
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave driving a software SPI master.
// Follows SPI_SLAVE_CPHA1_EN to run mode 1 instead of mode 0.
module tb_spi_slave;

    localparam int HALF = 8;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        nss = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic [7:0]  flag;
    logic [7:0]  flag_clr = '0;

    spi_slave dut (
        .clk(clk), .rst(rst), .sck(sck), .nss(nss), .mosi(mosi),
        .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .flag(flag), .flag_clr(flag_clr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rx_cyc = -1;
    int smp_cyc = 0;
    logic [15:0] exp_q[$];
    logic [15:0] held = '0;
    bit mdl_full = 1'b0;
    logic rv_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare process: every delivered word against the model queue,
    // and a held word must stay stable while rx_valid is high.
    always @(negedge clk) begin
        if (rst) begin
            rv_q = 1'b0;
        end else begin
            if (rx_valid && !rv_q) begin
                rx_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("rx_unexpected", {16'h0, rx_data}, 32'hxxxx_xxxx);
                    held = rx_data;
                end else begin
                    held = exp_q.pop_front();
                    chk("rx_word", {16'h0, rx_data}, {16'h0, held});
                end
            end else if (rx_valid) begin
                chk("rx_hold", {16'h0, rx_data}, {16'h0, held});
            end
            rv_q = rx_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_push(input logic [15:0] w);
        int t;
        t = 0;
        @(negedge clk);
        tx_data  = w;
        tx_valid = 1'b1;
        while (!tx_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t == 400) chk("tx_push_timeout", 32'd0, 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // A completed frame yields a word unless an unaccepted one is pending.
    task automatic model_rx(input logic [15:0] w);
        if (!mdl_full || rx_ready) begin
            exp_q.push_back(w);
            mdl_full = !rx_ready;
        end
    endtask

    task automatic bits(input logic [15:0] w, input int n,
                        output logic [15:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
`ifdef SPI_SLAVE_CPHA1_EN
            sck  = 1'b1;
            mosi = w[15-i];
            tick(HALF);
            sck = 1'b0;
            got = {got[14:0], miso};
            smp_cyc = cyc;
            tick(HALF);
`else
            mosi = w[15-i];
            tick(HALF);
            sck = 1'b1;
            got = {got[14:0], miso};
            smp_cyc = cyc;
            tick(HALF);
            sck = 1'b0;
`endif
        end
    endtask

    task automatic frame(input logic [15:0] w, input int n,
                         input bit exp_rx, output logic [15:0] got);
        if (exp_rx) model_rx(w);
        nss = 1'b0;
        tick(HALF);
        bits(w, n, got);
        tick(HALF);
        nss = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic clr_flags(input logic [7:0] v);
        @(negedge clk);
        flag_clr = v;
        tick(1);
        flag_clr = '0;
        tick(1);
    endtask

    initial begin
        logic [15:0] g, g2;

        tick(5);
        chk("rst_miso", {31'h0, miso}, 32'h0);
        chk("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
        chk("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        chk("rst_rx_data", {16'h0, rx_data}, 32'h0);
        chk("rst_flag", {24'h0, flag}, 32'h0);
        rst = 1'b0;
        tick(10);

        // Basic frame.
        tx_push(16'hA5C3);
        tick(1);
        chk("tx_ready_full", {31'h0, tx_ready}, 32'h0);
        model_rx(16'h000A);
        rx_cyc = -1;
        nss = 1'b0;
        tick(HALF);
        chk("busy_mid", {24'h0, flag}, 32'h01);
        bits(16'h000A, 16, g);
        tick(HALF);
        nss = 1'b1;
        tick(2 * HALF);
        chk("basic_miso", {16'h0, g}, 32'hA5C3);
        chk("basic_rx_data", {16'h0, rx_data}, 32'h000A);
        chk("basic_lat", {31'h0, rx_cyc > smp_cyc &&
                          rx_cyc - smp_cyc <= SYNC + 2}, 32'h1);
        chk("basic_flag", {24'h0, flag}, 32'h0);
        chk("basic_tx_ready", {31'h0, tx_ready}, 32'h1);

        // Underrun.
        frame(16'h3C3C, 16, 1'b1, g);
        chk("udr_miso", {16'h0, g}, 32'h0000);
        chk("udr_flag", {24'h0, flag}, 32'h04);
        clr_flags(8'h04);
        chk("udr_clr", {24'h0, flag}, 32'h0);

        // Overrun.
        rx_ready = 1'b0;
        tx_push(16'hBEEF);
        frame(16'h1234, 16, 1'b1, g);
        chk("ovr_miso1", {16'h0, g}, 32'hBEEF);
        tx_push(16'hCAFE);
        frame(16'h5678, 16, 1'b1, g);
        chk("ovr_miso2", {16'h0, g}, 32'hCAFE);
        chk("ovr_rx_data", {16'h0, rx_data}, 32'h1234);
        chk("ovr_rx_valid", {31'h0, rx_valid}, 32'h1);
        chk("ovr_flag", {24'h0, flag}, 32'h02);
        rx_ready = 1'b1;
        mdl_full = 1'b0;
        tick(2);
        chk("ovr_drain", {31'h0, rx_valid}, 32'h0);
        clr_flags(8'h02);
        chk("ovr_clr", {24'h0, flag}, 32'h0);

        // Back-to-back frames under one nss low period.
        tx_push(16'h1111);
        model_rx(16'hABCD);
        model_rx(16'h4321);
        nss = 1'b0;
        tick(HALF);
        fork
            tx_push(16'h2222);
        join_none
        bits(16'hABCD, 16, g);
        bits(16'h4321, 16, g2);
        tick(HALF);
        nss = 1'b1;
        tick(2 * HALF);
        chk("b2b_miso1", {16'h0, g}, 32'h1111);
        chk("b2b_miso2", {16'h0, g2}, 32'h2222);
        chk("b2b_rx_data", {16'h0, rx_data}, 32'h4321);
        chk("b2b_flag", {24'h0, flag}, 32'h0);

        // Abort after 7 bits.
        tx_push(16'h7777);
        frame(16'hF0F0, 7, 1'b0, g);
        chk("abt_flag", {24'h0, flag}, 32'h08);
        clr_flags(8'h08);
        chk("abt_clr", {24'h0, flag}, 32'h0);

        // Reset mid-frame, then a clean frame.
        tx_push(16'h9999);
        nss = 1'b0;
        tick(HALF);
        bits(16'hFFFF, 5, g);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("mrst_flag", {24'h0, flag}, 32'h0);
        chk("mrst_tx_ready", {31'h0, tx_ready}, 32'h1);
        chk("mrst_rx_valid", {31'h0, rx_valid}, 32'h0);
        bits(16'hFFFF, 16, g);
        tick(HALF);
        chk("mrst_ignored", {24'h0, flag}, 32'h0);
        chk("mrst_miso", {16'h0, g}, 32'h0000);
        nss = 1'b1;
        tick(2 * HALF);
        tx_push(16'h5A5A);
        frame(16'hC0DE, 16, 1'b1, g);
        chk("post_miso", {16'h0, g}, 32'h5A5A);
        chk("post_rx_data", {16'h0, rx_data}, 32'hC0DE);
        chk("post_flag", {24'h0, flag}, 32'h0);

        tick(4);
        chk("rx_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
